// File: rtl/write_back_stage_pkg.sv
// -----------------------------------------------------------------------------
// write_back_stage_pkg
// Shared constants and types for the write-back stage of the 16-bit core.
//   - DATA_W / REG_AW       : datapath width and register address width
//   - CTRL_* indices        : positions of wbEn / memToReg / outEn inside the
//                             35-bit pipeline control bus; the WB stage keeps
//                             only the top slice starting at CTRL_WB_LSB
//   - out_state_t           : output-port FSM encoding (IDLE=0, PEND=1)
//   - select_result()       : write-back result mux
// No ports (package).
// -----------------------------------------------------------------------------
package write_back_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  // Control bus layout: the write-back controls occupy the top three bits.
  localparam int CTRL_W              = 35;
  localparam int CTRL_WB_EN_BIT      = 32;
  localparam int CTRL_MEM_TO_REG_BIT = 33;
  localparam int CTRL_OUT_EN_BIT     = 34;
  localparam int CTRL_WB_LSB         = CTRL_WB_EN_BIT;
  localparam int WB_CTRL_W           = CTRL_W - CTRL_WB_LSB;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_PEND = 1'b1
  } out_state_t;

  // Loads return memory data, everything else returns the ALU result.
  function automatic logic [DATA_W-1:0] select_result(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] read_data,
    input logic [DATA_W-1:0] alu_result
  );
    return mem_to_reg ? read_data : alu_result;
  endfunction

endpackage

// File: rtl/write_back_stage_out_port_reg.sv
// -----------------------------------------------------------------------------
// out_port_reg
// Output-port register with valid/ready handshake and the stall term for an
// OUT instruction that cannot yet be loaded into the port.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   out_req    : WB register holds a valid OUT instruction
//   res        : write-back result (value to present on the port)
//   outReady   : consumer accepts outPort this cycle
//   outPort    : port data (stable while outValid=1 and outReady=0)
//   outValid   : port holds an unaccepted value
//   stall      : a new OUT waits behind an unaccepted one
// -----------------------------------------------------------------------------
module out_port_reg
  import write_back_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              out_req,
  input  logic [DATA_W-1:0] res,
  input  logic              outReady,
  output logic [DATA_W-1:0] outPort,
  output logic              outValid,
  output logic              stall
);

  out_state_t        state_r;
  out_state_t        state_next_s;
  logic              load_s;
  logic [DATA_W-1:0] port_r;

  // State register; reset discards any pending value at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= OUT_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: PEND is left only when the consumer takes the value
  // and no replacement OUT is waiting in the WB register.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      OUT_IDLE: begin
        if (out_req) state_next_s = OUT_PEND;
        else         state_next_s = OUT_IDLE;
      end
      OUT_PEND: begin
        if (outReady && !out_req) state_next_s = OUT_IDLE;
        else                      state_next_s = OUT_PEND;
      end
      default: state_next_s = OUT_IDLE;
    endcase
  end

  // Output logic: port load enable, stall and valid flag.
  always_comb begin
    load_s   = 1'b0;
    stall    = 1'b0;
    outValid = 1'b0;
    case (state_r)
      OUT_IDLE: begin
        load_s = out_req;
      end
      OUT_PEND: begin
        outValid = 1'b1;
        // A replacement value may enter only in the cycle the old one leaves.
        load_s   = out_req & outReady;
        stall    = out_req & ~outReady;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Port data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      port_r <= res;
    end else begin
      port_r <= port_r;
    end
  end

  assign outPort = port_r;

endmodule

// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
// Final pipeline stage: MEM/WB register, result select, register-file write
// back to decode, and the OUT port (via out_port_reg).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   memValid ... memOutEn    : instruction presented by the memory stage
//   stall                    : hold memory stage and earlier stages
//   regWrite, Rdst, writeData: register-file write port toward decode
//   outPort, outValid        : output port, valid/ready handshake
//   outReady                 : consumer accepts outPort this cycle
// Optional build macro WB_FORWARD_EN adds fwdValid/fwdRdst/fwdData for the
// execute-stage forwarding mux.
// -----------------------------------------------------------------------------
module write_back_stage
  import write_back_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              memValid,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic [DATA_W-1:0] memReadData,
  input  logic [REG_AW-1:0] memRdst,
  input  logic              memWbEn,
  input  logic              memMemToReg,
  input  logic              memOutEn,
  output logic              stall,
  output logic              regWrite,
  output logic [REG_AW-1:0] Rdst,
  output logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] outPort,
  output logic              outValid,
  input  logic              outReady
`ifdef WB_FORWARD_EN
  ,
  output logic              fwdValid,
  output logic [REG_AW-1:0] fwdRdst,
  output logic [DATA_W-1:0] fwdData
`endif
);

  localparam int WB_EN_IDX      = CTRL_WB_EN_BIT      - CTRL_WB_LSB;
  localparam int MEM_TO_REG_IDX = CTRL_MEM_TO_REG_BIT - CTRL_WB_LSB;
  localparam int OUT_EN_IDX     = CTRL_OUT_EN_BIT     - CTRL_WB_LSB;

  logic                 valid_r;
  logic [DATA_W-1:0]    alu_r;
  logic [DATA_W-1:0]    rdata_r;
  logic [REG_AW-1:0]    rdst_r;
  logic [WB_CTRL_W-1:0] ctrl_r;
  logic [WB_CTRL_W-1:0] ctrl_in_s;
  logic [DATA_W-1:0]    res_s;
  logic                 out_req_s;

  // Pack the incoming control flags into their control-bus slice.
  always_comb begin
    ctrl_in_s                 = {WB_CTRL_W{1'b0}};
    ctrl_in_s[WB_EN_IDX]      = memWbEn;
    ctrl_in_s[MEM_TO_REG_IDX] = memMemToReg;
    ctrl_in_s[OUT_EN_IDX]     = memOutEn;
  end

  // MEM/WB pipeline register; frozen while an OUT waits for the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      alu_r   <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      rdst_r  <= {REG_AW{1'b0}};
      ctrl_r  <= {WB_CTRL_W{1'b0}};
    end else if (!stall) begin
      valid_r <= memValid;
      alu_r   <= memAluResult;
      rdata_r <= memReadData;
      rdst_r  <= memRdst;
      ctrl_r  <= ctrl_in_s;
    end else begin
      valid_r <= valid_r;
      alu_r   <= alu_r;
      rdata_r <= rdata_r;
      rdst_r  <= rdst_r;
      ctrl_r  <= ctrl_r;
    end
  end

  assign res_s     = select_result(ctrl_r[MEM_TO_REG_IDX], rdata_r, alu_r);
  assign out_req_s = valid_r & ctrl_r[OUT_EN_IDX];

  // A stalled instruction must not write yet: it retires (and writes) only in
  // the cycle its OUT value is taken into the port register.
  assign regWrite  = valid_r & ctrl_r[WB_EN_IDX] & ~stall;
  assign Rdst      = rdst_r;
  assign writeData = res_s;

`ifdef WB_FORWARD_EN
  assign fwdValid = regWrite;
  assign fwdRdst  = rdst_r;
  assign fwdData  = res_s;
`endif

  out_port_reg u_out_port_reg (
    .clk      (clk),
    .rst      (rst),
    .out_req  (out_req_s),
    .res      (res_s),
    .outReady (outReady),
    .outPort  (outPort),
    .outValid (outValid),
    .stall    (stall)
  );

endmodule
